// File: rtl/usb_led_pkg.sv
// Shared mode encodings and counter widths for the USB status-LED engine.
package usb_led_pkg;

    localparam logic [1:0] LED_OFF   = 2'd0;
    localparam logic [1:0] LED_ON    = 2'd1;
    localparam logic [1:0] LED_BLINK = 2'd2;
    localparam logic [1:0] LED_ACT   = 2'd3;

    localparam int HOLD_W = 16;
    localparam int PWM_W  = 4;

endpackage

// File: rtl/usb_led_chan.sv
// One LED channel: retriggerable activity hold counter, mode mux and registered output.
module usb_led_chan
    import usb_led_pkg::*;
#(
    parameter int ACT_HOLD_MS    = 50,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] mode_i,
    input  logic       event_i,
    input  logic       tick_i,
    input  logic       beat_i,
    input  logic       gate_i,
    output logic       led_o
);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              led_q, led_d;
    logic              lit;

    always_comb begin
        hold_d = hold_q;
        // A fresh event always reloads, even on a tick cycle, so the stretch restarts in full.
        if (event_i) begin
            hold_d = HOLD_W'(ACT_HOLD_MS);
        end else if (tick_i && (hold_q != '0)) begin
            hold_d = hold_q - 1'b1;
        end

        lit = 1'b0;
        case (mode_i)
            LED_OFF:   lit = 1'b0;
            LED_ON:    lit = 1'b1;
            LED_BLINK: lit = beat_i;
            LED_ACT:   lit = (hold_q != '0);
            default:   lit = 1'b0;
        endcase

        led_d = (lit & gate_i) ^ LED_ACTIVE_LOW;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
            led_q  <= LED_ACTIVE_LOW;
        end else begin
            hold_q <= hold_d;
            led_q  <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/usb_led_status.sv
// Status-indicator engine: shared ms prescaler, heartbeat and PWM counters feeding
// NUM_LEDS channels. Define LED_PWM_EN to add per-channel brightness (bright_i).
module usb_led_status
    import usb_led_pkg::*;
#(
    parameter int CLK_FREQ       = 48000000,
    parameter int NUM_LEDS       = 2,
    parameter int BLINK_MS       = 500,
    parameter int ACT_HOLD_MS    = 50,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [2*NUM_LEDS-1:0] mode_i,
    input  logic [NUM_LEDS-1:0]   event_i,
`ifdef LED_PWM_EN
    input  logic [4*NUM_LEDS-1:0] bright_i,
`endif
    output logic [NUM_LEDS-1:0]   led_o,
    output logic                  tick_o,
    output logic                  beat_o
);

    localparam int DIV   = CLK_FREQ / 1000;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int MS_W  = 16;

    logic [PRE_W-1:0] presc_q, presc_d;
    logic             tick_q, tick_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic             beat_q, beat_d;
`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_q, pwm_d;
`endif

    always_comb begin
        tick_d  = (presc_q == PRE_W'(DIV - 1));
        presc_d = tick_d ? '0 : presc_q + 1'b1;

        // Heartbeat advances on the registered tick so it shares the ms grid with the hold counters.
        ms_d   = ms_q;
        beat_d = beat_q;
        if (tick_q) begin
            if (ms_q == MS_W'(BLINK_MS - 1)) begin
                ms_d   = '0;
                beat_d = ~beat_q;
            end else begin
                ms_d = ms_q + 1'b1;
            end
        end
`ifdef LED_PWM_EN
        pwm_d = pwm_q + 1'b1;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            ms_q    <= '0;
            beat_q  <= 1'b0;
`ifdef LED_PWM_EN
            pwm_q   <= '0;
`endif
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            ms_q    <= ms_d;
            beat_q  <= beat_d;
`ifdef LED_PWM_EN
            pwm_q   <= pwm_d;
`endif
        end
    end

    assign tick_o = tick_q;
    assign beat_o = beat_q;

    for (genvar n = 0; n < NUM_LEDS; n++) begin : g_chan
        logic gate;
`ifdef LED_PWM_EN
        assign gate = (pwm_q < bright_i[4*n +: 4]);
`else
        assign gate = 1'b1;
`endif
        usb_led_chan #(
            .ACT_HOLD_MS    (ACT_HOLD_MS),
            .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
        ) u_chan (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .mode_i  (mode_i[2*n +: 2]),
            .event_i (event_i[n]),
            .tick_i  (tick_q),
            .beat_i  (beat_q),
            .gate_i  (gate),
            .led_o   (led_o[n])
        );
    end

endmodule

// File: tb/tb_usb_led_status.sv
// Bench for usb_led_status at 8 kHz (1 ms = 8 cycles), BLINK_MS=4, ACT_HOLD_MS=3.
module tb_usb_led_status;
    import usb_led_pkg::*;

    localparam int NL   = 2;
    localparam bit ALOW = 1'b0;

    logic            clk = 1'b0;
    logic            rst;
    logic [2*NL-1:0] mode;
    logic [NL-1:0]   ev;
    logic [NL-1:0]   led;
    logic            tick;
    logic            beat;
`ifdef LED_PWM_EN
    logic [4*NL-1:0] bright;
`endif

    always #5 clk = ~clk;

    usb_led_status #(
        .CLK_FREQ       (8000),
        .NUM_LEDS       (NL),
        .BLINK_MS       (4),
        .ACT_HOLD_MS    (3),
        .LED_ACTIVE_LOW (ALOW)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .mode_i   (mode),
        .event_i  (ev),
`ifdef LED_PWM_EN
        .bright_i (bright),
`endif
        .led_o    (led),
        .tick_o   (tick),
        .beat_o   (beat)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time since reset release decides tick and heartbeat;
    // each channel counts ms ticks since its last event.
    int            m_n;
    int            m_ticks [NL];
    bit            m_seen  [NL];
    logic [NL-1:0] m_led;

    function automatic bit m_tick(input int k);
        return (k > 0) && (k % 8 == 0);
    endfunction

    function automatic bit m_beat(input int k);
        return (k > 0) ? bit'(((k - 1) / 32) % 2) : 1'b0;
    endfunction

    initial begin
        m_n = 0;
        m_led = {NL{ALOW}};
        for (int c = 0; c < NL; c++) begin
            m_ticks[c] = 0;
            m_seen[c]  = 1'b0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                m_n = 0;
                m_led = {NL{ALOW}};
                for (int c = 0; c < NL; c++) begin
                    m_ticks[c] = 0;
                    m_seen[c]  = 1'b0;
                end
            end else begin
                for (int c = 0; c < NL; c++) begin
                    bit on;
                    case (mode[2*c +: 2])
                        2'd0:    on = 1'b0;
                        2'd1:    on = 1'b1;
                        2'd2:    on = m_beat(m_n);
                        default: on = m_seen[c] && (m_ticks[c] < 3);
                    endcase
`ifdef LED_PWM_EN
                    if ((m_n % 16) >= int'(bright[4*c +: 4])) on = 1'b0;
`endif
                    m_led[c] = on ^ ALOW;
                end
                for (int c = 0; c < NL; c++) begin
                    if (ev[c]) begin
                        m_seen[c]  = 1'b1;
                        m_ticks[c] = 0;
                    end else if (m_tick(m_n) && m_ticks[c] < 1000) begin
                        m_ticks[c] = m_ticks[c] + 1;
                    end
                end
                m_n = m_n + 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model_tick", tick, m_tick(m_n));
                check("model_beat", beat, m_beat(m_n));
                check("model_led",  led,  m_led);
            end
        end
    end

    task automatic cyc(input int k);
        for (int i = 0; i < k; i++) @(negedge clk);
    endtask

    initial begin
        int k;
        int ones;
        logic prev;

        rst  = 1'b1;
        mode = '0;
        ev   = '0;
`ifdef LED_PWM_EN
        bright = '0;
`endif
        @(posedge clk);
        chk_en = 1'b1;

        // Reset state and prescaler start-up
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_led",  led,  {NL{ALOW}});
            check("rst_tick", tick, 0);
        end
        rst = 1'b0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (tick) begin k = i; break; end
        end
        check("first_tick", k, 8);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (tick) begin k = i; break; end
        end
        check("tick_period", k, 8);

        // Heartbeat blink period and phase sharing
        mode[1:0] = LED_BLINK;
        cyc(1);
        prev = led[0];
        k = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (led[0] !== prev) begin k = i; break; end
        end
        check("blink_edge_seen", (k > 0), 1);
        prev = led[0];
        k = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (led[0] !== prev) begin k = i; break; end
        end
        check("blink_half_period", k, 32);
        cyc(5);
        mode[3:2] = LED_BLINK;
        cyc(2);
        for (int i = 0; i < 40; i++) begin
            check("blink_phase", led[1], led[0]);
            cyc(1);
        end

        // Single activity pulse
        mode = {LED_OFF, LED_ACT};
        cyc(2);
        check("act_idle", led[0] ^ ALOW, 0);
        ev[0] = 1'b1;
        cyc(1);
        ev[0] = 1'b0;
        check("act_lat1", led[0] ^ ALOW, 0);
        cyc(1);
        check("act_lat2", led[0] ^ ALOW, 1);
        k = 0;
        for (int i = 3; i <= 60; i++) begin
            @(negedge clk);
            if ((led[0] ^ ALOW) == 1'b0) begin k = i; break; end
        end
        check("pulse_len_in_range", (k >= 19 && k <= 26), 1);

        // Continuous events, then release
        ev[0] = 1'b1;
        cyc(2);
        ones = 0;
        for (int i = 0; i < 98; i++) begin
            @(negedge clk);
            if ((led[0] ^ ALOW) == 1'b0) ones++;
        end
        check("held_dark_cycles", ones, 0);
        ev[0] = 1'b0;
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if ((led[0] ^ ALOW) == 1'b0) begin k = i; break; end
        end
        check("release_len_in_range", (k >= 18 && k <= 25), 1);

        // Mid-stretch reset
        mode = {LED_BLINK, LED_ACT};
        cyc(30);
        ev[0] = 1'b1;
        cyc(1);
        ev[0] = 1'b0;
        cyc(4);
        check("pre_rst_on", led[0] ^ ALOW, 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("mid_rst_led",  led,  {NL{ALOW}});
        check("mid_rst_beat", beat, 0);
        check("mid_rst_tick", tick, 0);
        cyc(3);
        check("no_residual", led[0] ^ ALOW, 0);

        // Solid / PWM on-state
        mode = {LED_OFF, LED_ON};
`ifdef LED_PWM_EN
        bright[3:0] = 4'd4;
        cyc(2);
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (led[0] ^ ALOW) ones++;
        end
        check("pwm_duty4", ones, 8);
        bright[3:0] = 4'd0;
        cyc(2);
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (led[0] ^ ALOW) ones++;
        end
        check("pwm_duty0", ones, 0);
`else
        cyc(2);
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (led[0] ^ ALOW) ones++;
        end
        check("solid_on", ones, 16);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) mode = (2*NL)'($urandom);
            for (int c = 0; c < NL; c++) ev[c] = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 599) == 0);
`ifdef LED_PWM_EN
            if ($urandom_range(0, 63) == 0) bright = (4*NL)'($urandom);
`endif
        end
        rst = 1'b0;
        ev  = '0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
